// File: rtl/mcu_mux_array.sv
// mcu_mux_array: registered routing crossbar between memory, host data and N convolvers.
// Define MCU_MUX_ARRAY_INREG_EN to add an input register stage (latency 2 instead of 1).
`default_nettype none

module mcu_mux_array #(
  parameter int N           = 2,
  parameter int BITS_IMAGEN = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [N*BITS_IMAGEN-1:0]     i_DataConv,
  input  logic [(N+2)*BITS_IMAGEN-1:0] i_MemData,
  input  logic [3*BITS_IMAGEN-1:0]     i_Data,
  input  logic                         i_inputCtrl,
  input  logic                         i_memCtrl,
  input  logic                         i_convCtrl,
  output logic [3*N*BITS_IMAGEN-1:0]   o_DataConv,
  output logic [(N+2)*BITS_IMAGEN-1:0] o_MemData,
  output logic [3*BITS_IMAGEN-1:0]     o_Data
);

  localparam int B       = BITS_IMAGEN;
  localparam int CONV_WN = (N < 3) ? N : 3;

  logic [N*B-1:0]     dconv_s;
  logic [(N+2)*B-1:0] mem_s;
  logic [3*B-1:0]     data_s;
  logic               input_sel;
  logic               mem_sel;
  logic               conv_sel;

`ifdef MCU_MUX_ARRAY_INREG_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      dconv_s   <= '0;
      mem_s     <= '0;
      data_s    <= '0;
      input_sel <= 1'b0;
      mem_sel   <= 1'b0;
      conv_sel  <= 1'b0;
    end else begin
      dconv_s   <= i_DataConv;
      mem_s     <= i_MemData;
      data_s    <= i_Data;
      input_sel <= i_inputCtrl;
      mem_sel   <= i_memCtrl;
      conv_sel  <= i_convCtrl;
    end
  end
`else
  assign dconv_s   = i_DataConv;
  assign mem_s     = i_MemData;
  assign data_s    = i_Data;
  assign input_sel = i_inputCtrl;
  assign mem_sel   = i_memCtrl;
  assign conv_sel  = i_convCtrl;
`endif

  logic [3*N*B-1:0]   conv_nxt;
  logic [(N+2)*B-1:0] mem_nxt;
  logic [3*B-1:0]     data_nxt;

  // Slot k's window {w(k+2),w(k+1),w(k)} is a contiguous slice of the memory bus.
  always_comb begin
    conv_nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (conv_sel) conv_nxt[3*k*B +: 3*B] = data_s;
      else          conv_nxt[3*k*B +: 3*B] = mem_s[k*B +: 3*B];
    end
  end

  always_comb begin
    mem_nxt = '0;
    if (mem_sel) mem_nxt[N*B-1:0] = dconv_s;
    else         mem_nxt[3*B-1:0] = data_s;
  end

  always_comb begin
    data_nxt = '0;
    if (input_sel) begin
      for (int w = 0; w < CONV_WN; w++) data_nxt[w*B +: B] = dconv_s[w*B +: B];
    end else begin
      data_nxt = mem_s[3*B-1:0];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_DataConv <= '0;
      o_MemData  <= '0;
      o_Data     <= '0;
    end else begin
      o_DataConv <= conv_nxt;
      o_MemData  <= mem_nxt;
      o_Data     <= data_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mcu_mux_array.sv
// tb_mcu_mux_array: randomized self-checking bench for mcu_mux_array (N=2, B=8, no input regs).
`default_nettype none

module tb_mcu_mux_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dconv;
  logic [31:0] mem;
  logic [23:0] data;
  logic        in_ctrl, mem_ctrl, conv_ctrl;
  logic [47:0] o_conv;
  logic [31:0] o_mem;
  logic [23:0] o_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mcu_mux_array #(.N(2), .BITS_IMAGEN(8)) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_DataConv (dconv),
    .i_MemData  (mem),
    .i_Data     (data),
    .i_inputCtrl(in_ctrl),
    .i_memCtrl  (mem_ctrl),
    .i_convCtrl (conv_ctrl),
    .o_DataConv (o_conv),
    .o_MemData  (o_mem),
    .o_Data     (o_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: build results word by word from the routing rules.
  function automatic logic [47:0] ref_conv(logic [31:0] m, logic [23:0] d, logic sel);
    logic [7:0] mw [4];
    logic [7:0] dw [3];
    logic [47:0] r = '0;
    for (int i = 0; i < 4; i++) mw[i] = m[8*i +: 8];
    for (int i = 0; i < 3; i++) dw[i] = d[8*i +: 8];
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++)
        r = r | (48'(sel ? dw[j] : mw[k+j]) << (8*(3*k+j)));
    return r;
  endfunction

  function automatic logic [31:0] ref_mem(logic [15:0] c, logic [23:0] d, logic sel);
    return sel ? {16'h0, c} : {8'h0, d};
  endfunction

  function automatic logic [23:0] ref_data(logic [31:0] m, logic [15:0] c, logic sel);
    return sel ? {8'h0, c} : m[23:0];
  endfunction

  task automatic step_check(input string tag);
    logic [47:0] ec;
    logic [31:0] em;
    logic [23:0] ed;
    ec = ref_conv(mem, data, conv_ctrl);
    em = ref_mem(dconv, data, mem_ctrl);
    ed = ref_data(mem, dconv, in_ctrl);
    @(posedge clk);
    #1;
    check({tag, ".conv"}, 64'(o_conv), 64'(ec));
    check({tag, ".mem"},  64'(o_mem),  64'(em));
    check({tag, ".data"}, 64'(o_data), 64'(ed));
  endtask

  task automatic randomize_inputs();
    dconv     = 16'($urandom);
    mem       = $urandom;
    data      = 24'($urandom);
    in_ctrl   = 1'($urandom);
    mem_ctrl  = 1'($urandom);
    conv_ctrl = 1'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    dconv = 16'hA5C3; mem = 32'hDEADBEEF; data = 24'h123456;
    in_ctrl = 1'b1; mem_ctrl = 1'b1; conv_ctrl = 1'b1;
    #3;
    check("rst.conv", 64'(o_conv), 64'h0);
    check("rst.mem",  64'(o_mem),  64'h0);
    check("rst.data", 64'(o_data), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold.conv", 64'(o_conv), 64'h0);
    check("rst_hold.mem",  64'(o_mem),  64'h0);
    check("rst_hold.data", 64'(o_data), 64'h0);
    rst_n = 1'b1;

    // Directed vectors
    mem = 32'h00010001; dconv = 16'h0001; data = 24'h001000;
    conv_ctrl = 1'b0; mem_ctrl = 1'b0; in_ctrl = 1'b0;
    step_check("dir0");
    check("dir0.conv_lit", 64'(o_conv), 64'h000100010001);
    check("dir0.mem_lit",  64'(o_mem),  64'h00001000);
    check("dir0.data_lit", 64'(o_data), 64'h010001);
    conv_ctrl = 1'b1; mem_ctrl = 1'b1; in_ctrl = 1'b1;
    step_check("dir1");
    check("dir1.conv_lit", 64'(o_conv), 64'h001000001000);
    check("dir1.mem_lit",  64'(o_mem),  64'h00000001);
    check("dir1.data_lit", 64'(o_data), 64'h000001);

    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      step_check("rand");
    end

    // Reset mid-operation clears outputs immediately, between edges
    randomize_inputs();
    mem = mem | 32'h1; data = data | 24'h1; dconv = dconv | 16'h1;
    step_check("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.conv", 64'(o_conv), 64'h0);
    check("mid_rst.mem",  64'(o_mem),  64'h0);
    check("mid_rst.data", 64'(o_data), 64'h0);
    @(posedge clk);
    #1;
    check("mid_rst_hold.mem", 64'(o_mem), 64'h0);
    rst_n = 1'b1;
    step_check("post_rst");

    for (int i = 0; i < 100; i++) begin
      randomize_inputs();
      step_check("rand2");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mcu_mux_array.md
MCU_MUX_ARRAY -- requirements
Module: mcu_mux_array

Interface
REQ-001 Parameter N, default 2: number of convolvers; N >= 1.
REQ-002 Parameter BITS_IMAGEN, default 8: pixel word width B; B >= 1.
REQ-003 i_clock  input  1: single clock; all registers rising-edge.
REQ-004 i_reset  input  1: asynchronous, active-low reset.
REQ-005 i_DataConv  input  N*B: convolver results; word k is bits [k*B +: B].
REQ-006 i_MemData  input  (N+2)*B: memory read data, N+2 words.
REQ-007 i_Data  input  3*B: host/input data, 3 words.
REQ-008 i_inputCtrl  input  1: o_Data source select.
REQ-009 i_memCtrl  input  1: o_MemData source select.
REQ-010 i_convCtrl  input  1: o_DataConv source select.
REQ-011 o_DataConv  output  3*N*B: convolver inputs; slot k (3 words) is bits [3*k*B +: 3*B].
REQ-012 o_MemData  output  (N+2)*B: memory write data.
REQ-013 o_Data  output  3*B: host readback data.

Function
REQ-014 All three outputs SHALL be registered: each output equals its selected value, computed from the inputs sampled at the previous rising edge (latency 1 cycle).
REQ-015 i_convCtrl=0: o_DataConv slot k SHALL be {MemData word k+2, word k+1, word k} (sliding 3-word window), k=0..N-1.
REQ-016 i_convCtrl=1: every o_DataConv slot SHALL equal i_Data (broadcast, kernel load).
REQ-017 i_memCtrl=0: o_MemData words 0..2 SHALL be i_Data words 0..2; words 3..N+1 SHALL be 0.
REQ-018 i_memCtrl=1: o_MemData words 0..N-1 SHALL be i_DataConv; words N, N+1 SHALL be 0.
REQ-019 i_inputCtrl=0: o_Data SHALL be i_MemData words 0..2.
REQ-020 i_inputCtrl=1: o_Data words 0..min(N,3)-1 SHALL be i_DataConv words; remaining words 0.
REQ-021 The three selects SHALL be independent; any combination, including simultaneous changes, is legal and takes effect on the next edge.
REQ-022 No arithmetic; data SHALL pass bit-exact, never truncated or reordered beyond REQ-015..020.

Reset
REQ-023 i_reset low SHALL immediately clear o_DataConv, o_MemData and o_Data (and any internal registers) to 0, independent of i_clock.
REQ-024 Reset asserted mid-operation SHALL discard in-flight data; first valid output appears one edge (two with REQ-026) after deassertion.

Configuration
REQ-025 Macro MCU_MUX_ARRAY_INREG_EN undefined: single output register stage, latency 1.
REQ-026 MCU_MUX_ARRAY_INREG_EN defined: all data and select inputs SHALL additionally be registered before the muxes, latency 2; input registers reset to 0 per REQ-023.

Verification (N=2, B=8, INREG off)
REQ-027 i_reset low with nonzero inputs -> all outputs 0 immediately, held 0 while low.
REQ-028 i_MemData=0x00010001, i_convCtrl=0 -> o_DataConv=0x000100010001 one edge later.
REQ-029 i_Data=0x001000, i_convCtrl=1 -> o_DataConv=0x001000001000.
REQ-030 i_Data=0x001000, i_DataConv=0x0001: i_memCtrl=0 -> o_MemData=0x00001000; i_memCtrl=1 -> 0x00000001.
REQ-031 i_MemData=0x00010001, i_DataConv=0x0001: i_inputCtrl=0 -> o_Data=0x010001; i_inputCtrl=1 -> o_Data=0x000001.
REQ-032 Toggle all selects in one cycle -> all outputs switch together on next edge; rerun REQ-028 with INREG defined -> result after 2 edges.
